arbiter_sync_rr: RTL

Round-robin arbiter that shares one synchronous memory port between 2**N requesters. It is fair: after a requester is granted, it becomes the lowest-priority requester. It sits between the memory controller and client blocks (display fetch, ADC capture, CPU bridge) and replaces fixed-priority arbitration wherever a requester could otherwise be starved. It has one request in flight at a time, and read data is returned to the requester tagged by the memory.

---
 rtl/arbiter_sync_rr_pkg.sv | 38 +++
 rtl/arbiter_sync_rr_if.sv | 41 ++++
 rtl/arbiter_sync_rr_select.sv | 25 ++
 rtl/arbiter_sync_rr.sv | 138 +++++++++++++
 4 files changed

// File: rtl/arbiter_sync_rr_pkg.sv
// Shared types and the rotate-priority pick used by the round-robin memory-port arbiter.
package arbiter_pkg;

  localparam int N_MAX  = 4;
  localparam int NR_MAX = 1 << N_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [N_MAX-1:0] idx;
  } rr_pick_t;

  // Walks offsets from the highest down so the lowest offset from ptr is the last to land.
  function automatic rr_pick_t rr_pick(input logic [NR_MAX-1:0] req,
                                       input logic [N_MAX-1:0]  ptr,
                                       input logic [N_MAX-1:0]  mask);
    rr_pick_t         res;
    logic [N_MAX-1:0] cand;
    res.found = 1'b0;
    res.idx   = {N_MAX{1'b0}};
    for (int i = NR_MAX - 1; i >= 0; i--) begin
      cand = (ptr + N_MAX'(i)) & mask;
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_sync_rr_if.sv
// Requester-side and memory-side signal bundle of the round-robin arbiter.
interface arbiter_sync_rr_if #(
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int N  = 2
);
  localparam int NR = 1 << N;

  logic [NR-1:0]    arb_req;
  logic [NR-1:0]    arb_wr;
  logic [NR*AN-1:0] arb_addr;
  logic [NR*DN-1:0] arb_data;
  logic [NR-1:0]    arb_ack;
  logic [NR-1:0]    arb_valid;
  logic [DN-1:0]    arb_mem;

  logic             mem_req;
  logic             mem_wr;
  logic [AN-1:0]    mem_addr;
  logic [DN-1:0]    mem_data;
  logic [N-1:0]     mem_id;
  logic             mem_ack;
  logic             mem_valid;
  logic [N-1:0]     mem_valid_id;
  logic [DN-1:0]    mem_rdata;

  modport slave (
    input  arb_req, arb_wr, arb_addr, arb_data,
    input  mem_ack, mem_valid, mem_valid_id, mem_rdata,
    output arb_ack, arb_valid, arb_mem,
    output mem_req, mem_wr, mem_addr, mem_data, mem_id
  );

  modport master (
    output arb_req, arb_wr, arb_addr, arb_data,
    output mem_ack, mem_valid, mem_valid_id, mem_rdata,
    input  arb_ack, arb_valid, arb_mem,
    input  mem_req, mem_wr, mem_addr, mem_data, mem_id
  );

endinterface

// File: rtl/arbiter_sync_rr_select.sv
// Combinational rotate-priority encoder: first requester at or after ptr, wrapping.
module rr_select
  import arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [(1<<N)-1:0] req_s,
  input  logic [N-1:0]      ptr_s,
  output logic              found_s,
  output logic [N-1:0]      idx_s
);

  localparam int               NR   = 1 << N;
  localparam logic [N_MAX-1:0] MASK = N_MAX'(NR - 1);

  rr_pick_t pick_s;
  logic     unused_pick_s;

  // Requests above NR are zero-filled, so the masked scan never selects them.
  assign pick_s        = rr_pick(NR_MAX'(req_s), N_MAX'(ptr_s), MASK);
  assign found_s       = pick_s.found;
  assign idx_s         = pick_s.idx[N-1:0];
  assign unused_pick_s = ^pick_s;

endmodule

// File: rtl/arbiter_sync_rr.sv
// Round-robin arbiter sharing one memory port among 2**N requesters, one request in flight.
module arbiter_sync_rr
  import arbiter_pkg::*;
#(
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int N  = 2
) (
  input  logic              clkSYS,
  input  logic              n_reset,
  arbiter_sync_rr_if.slave  bus
);

  localparam int            NR   = 1 << N;
  localparam logic [NR-1:0] BIT0 = {{(NR-1){1'b0}}, 1'b1};

  arb_state_t    state_r;
  arb_state_t    nxt_state_s;
  logic [N-1:0]  ptr_r;
  logic          found_s;
  logic [N-1:0]  win_s;
  logic          issue_s;
  logic          grant_s;

  logic          mem_req_r;
  logic          mem_wr_r;
  logic [AN-1:0] mem_addr_r;
  logic [DN-1:0] mem_data_r;
  logic [N-1:0]  mem_id_r;
  logic [NR-1:0] arb_ack_r;
  logic [NR-1:0] arb_valid_r;
  logic [DN-1:0] arb_mem_r;

  rr_select #(.N(N)) u_rr_select (
    .req_s   (bus.arb_req),
    .ptr_s   (ptr_r),
    .found_s (found_s),
    .idx_s   (win_s)
  );

  // State register
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) nxt_state_s = ISSUE;
        else         nxt_state_s = IDLE;
      end
      ISSUE: begin
        if (bus.mem_ack) nxt_state_s = HOLD;
        else             nxt_state_s = ISSUE;
      end
      HOLD:    nxt_state_s = IDLE;
      default: nxt_state_s = IDLE;
    endcase
  end

  // Output decode: when to capture a winner and when to report a grant
  always_comb begin
    issue_s = 1'b0;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) issue_s = 1'b1;
        else         issue_s = 1'b0;
      end
      ISSUE: begin
        if (bus.mem_ack) grant_s = 1'b1;
        else             grant_s = 1'b0;
      end
      HOLD: begin
        issue_s = 1'b0;
        grant_s = 1'b0;
      end
      default: begin
        issue_s = 1'b0;
        grant_s = 1'b0;
      end
    endcase
  end

  // Request path: the mem_* fields stay frozen from capture until the next win
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      mem_req_r  <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_addr_r <= {AN{1'b0}};
      mem_data_r <= {DN{1'b0}};
      mem_id_r   <= {N{1'b0}};
      ptr_r      <= {N{1'b0}};
      arb_ack_r  <= {NR{1'b0}};
    end else begin
      arb_ack_r <= grant_s ? (BIT0 << mem_id_r) : {NR{1'b0}};
      if (issue_s) begin
        mem_req_r  <= 1'b1;
        mem_wr_r   <= bus.arb_wr[win_s];
        mem_addr_r <= bus.arb_addr[int'(win_s)*AN +: AN];
        mem_data_r <= bus.arb_data[int'(win_s)*DN +: DN];
        mem_id_r   <= win_s;
      end else if (grant_s) begin
        mem_req_r <= 1'b0;
        ptr_r     <= mem_id_r + 1'b1;
      end
    end
  end

  // Read return, independent of the arbitration state
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      arb_valid_r <= {NR{1'b0}};
      arb_mem_r   <= {DN{1'b0}};
    end else begin
      arb_valid_r <= bus.mem_valid ? (BIT0 << bus.mem_valid_id) : {NR{1'b0}};
      if (bus.mem_valid) begin
        arb_mem_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_data  = mem_data_r;
  assign bus.mem_id    = mem_id_r;
  assign bus.arb_ack   = arb_ack_r;
  assign bus.arb_valid = arb_valid_r;
  assign bus.arb_mem   = arb_mem_r;

endmodule
